// File: rtl/mult_nxn_iter.sv
// Iterative WIDTHxWIDTH multiplier: one nonzero digit pair per cycle through a single
// shared DIGITxDIGIT multiplier, with sign/magnitude handling for two's-complement operands.
module mult_nxn_iter #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int ND = WIDTH / DIGIT;
    localparam int NP = ND * ND;
    localparam int JW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              neg;
    logic [NP-1:0]     consumed;
    logic [NP-1:0]     valid, pending, sel_mask;
    logic [JW-1:0]     sel_i, sel_j;
    logic              last;
    logic [DIGIT-1:0]  da [ND];
    logic [DIGIT-1:0]  db [ND];
    logic [2*DIGIT-1:0] digit_prod;
    logic [2*WIDTH-1:0] term;

    // Pair index is j*ND+i, so the lowest set bit is the next pair in j-major order.
    for (genvar gi = 0; gi < ND; gi++) begin : g_digit
        assign da[gi] = mag_a[gi*DIGIT +: DIGIT];
        assign db[gi] = mag_b[gi*DIGIT +: DIGIT];
        for (genvar gj = 0; gj < ND; gj++) begin : g_pair
            assign valid[gj*ND+gi] = (|da[gi]) && (|db[gj]);
        end
    end

    assign pending = valid & ~consumed;

    always_comb begin
        sel_i    = '0;
        sel_j    = '0;
        sel_mask = '0;
        for (int j = ND - 1; j >= 0; j--) begin
            for (int i = ND - 1; i >= 0; i--) begin
                if (pending[j*ND+i]) begin
                    sel_i    = JW'(i);
                    sel_j    = JW'(j);
                    sel_mask = NP'(1) << (j*ND+i);
                end
            end
        end
    end

    assign last       = ((pending & ~sel_mask) == '0);
    assign digit_prod = da[sel_i] * db[sel_j];
    assign term       = (2*WIDTH)'(digit_prod) << (DIGIT * (int'(sel_i) + int'(sel_j)));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last)  state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            consumed <= '0;
            product  <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        // Negating the most negative value yields its own bit pattern,
                        // which is exactly the unsigned magnitude 2^(WIDTH-1).
                        mag_a    <= (signed_mode && a[WIDTH-1]) ? -a : a;
                        mag_b    <= (signed_mode && b[WIDTH-1]) ? -b : b;
                        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        consumed <= '0;
                        product  <= '0;
                    end
                end
                CALC: begin
                    if (|pending) begin
                        product  <= product + term;
                        consumed <= consumed | sel_mask;
                    end
                end
                FIX: begin
                    if (neg) product <= -product;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_nxn_iter.sv
// Randomized and directed bench for mult_nxn_iter against a plain-arithmetic product model.
module tb_mult_nxn_iter;
    localparam int W = 32;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;
    longint unsigned last_prod = 0;

    mult_nxn_iter #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, longint unsigned got, longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_prod(logic [W-1:0] av, logic [W-1:0] bv, bit sm);
        longint sa, sb;
        if (sm) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            return longint'(sa * sb);
        end
        return longint'({32'b0, av}) * longint'({32'b0, bv});
    endfunction

    function automatic int nz_digits(logic [W-1:0] v, bit sm);
        longint unsigned m;
        int n = 0;
        m = (sm && v[W-1]) ? (64'h1_0000_0000 - longint'({32'b0, v})) : longint'({32'b0, v});
        for (int k = 0; k < W / D; k++)
            if (((m >> (k * D)) & 64'hFF) != 0) n++;
        return n;
    endfunction

    function automatic int ref_busy(logic [W-1:0] av, logic [W-1:0] bv, bit sm);
        int p;
        p = nz_digits(av, sm) * nz_digits(bv, sm);
        return ((p > 1) ? p : 1) + 1;
    endfunction

    // Called at a negedge; the operation is accepted at the next posedge.
    task automatic launch(logic [W-1:0] av, logic [W-1:0] bv, bit sm);
        a = av; b = bv; signed_mode = sm; start = 1'b1;
    endtask

    // Returns at the negedge of the done cycle with start released.
    task automatic complete(string tag, longint unsigned exp_prod, int exp_busy, bit toggle);
        int  bc = 0;
        bit  seen = 0;
        @(negedge clk);
        for (int c = 0; c < 300; c++) begin
            if (done) begin seen = 1; break; end
            if (busy) bc++;
            if (toggle) begin
                start = 1'b1; a = $urandom; b = $urandom; signed_mode = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, longint'(seen), 1);
        if (seen) begin
            check({tag, "_prod"}, product, exp_prod);
            check({tag, "_busy"}, longint'(bc), longint'(exp_busy));
        end
        $display("op %s prod=%0h busy=%0d", tag, product, bc);
        last_prod = exp_prod;
        start = 1'b0;
    endtask

    task automatic idle_check(string tag);
        @(negedge clk);
        check({tag, "_pulse"}, longint'(done), 0);
        check({tag, "_idle"}, longint'(busy), 0);
        check({tag, "_hold"}, product, last_prod);
    endtask

    typedef struct {
        logic [W-1:0]    av;
        logic [W-1:0]    bv;
        bit              sm;
        longint unsigned p;
        int              bz;
    } vec_t;

    vec_t dirs[6];

    initial begin
        int dseen;
        logic [W-1:0] ra, rb;
        bit rs;

        dirs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 17};
        dirs[1] = '{32'h01000001, 32'h00010000, 1'b0, 64'h0000010000010000, 3};
        dirs[2] = '{32'h00000000, 32'h12345678, 1'b0, 64'h0, 2};
        dirs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000, 2};
        dirs[4] = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFEB, 2};
        dirs[5] = '{32'hFFFFFFF9, 32'h00000003, 1'b0, 64'h00000002FFFFFFEB, 5};

        repeat (2) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_prod", product, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (dirs[k]) begin
            launch(dirs[k].av, dirs[k].bv, dirs[k].sm);
            complete($sformatf("dir%0d", k), dirs[k].p, dirs[k].bz, 1'b0);
            idle_check($sformatf("dir%0d", k));
        end

        // Start held and operands toggled while busy, then a back-to-back start in the done cycle.
        launch(32'd5, 32'd7, 1'b0);
        complete("toggle", 64'd35, 2, 1'b1);
        launch(32'd2, 32'd3, 1'b0);
        complete("b2b", 64'd6, 2, 1'b0);
        idle_check("b2b");

        // Abort mid-CALC.
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_prod", product, 0);
        @(negedge clk);
        reset = 1'b0;
        dseen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("abort_nodone", longint'(dseen), 0);
        launch(32'd2, 32'd3, 1'b0);
        complete("post_abort", 64'd6, 2, 1'b0);
        idle_check("post_abort");

        for (int n = 0; n < 60; n++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            for (int k = 0; k < W / D; k++) begin
                if ($urandom_range(0, 2) == 0) ra[k*D +: D] = '0;
                if ($urandom_range(0, 2) == 0) rb[k*D +: D] = '0;
            end
            launch(ra, rb, rs);
            complete($sformatf("rnd%0d", n), ref_prod(ra, rb, rs), ref_busy(ra, rb, rs), 1'b0);
            if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d", n));
        end
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_nxn_iter.md
MULT_NXN_ITER -- requirements
Module: mult_nxn_iter

Interface
- REQ-001 Parameter WIDTH, default 32: operand width in bits.
- REQ-002 Parameter DIGIT, default 8: digit width processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with WIDTH >= DIGIT.
- REQ-003 Derived ND = WIDTH/DIGIT: digits per operand.
- REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
- REQ-005 reset  input  1  asynchronous, active-high reset.
- REQ-006 start  input  1  request to begin a multiplication; sampled only in IDLE.
- REQ-007 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- REQ-008 a  input  WIDTH  multiplicand; sampled with start.
- REQ-009 b  input  WIDTH  multiplier; sampled with start.
- REQ-010 busy  output  1  high while a multiplication is in progress (states CALC, FIX).
- REQ-011 done  output  1  single-cycle pulse; product is final in that cycle.
- REQ-012 product  output  2*WIDTH  result register.

Function
- REQ-013 FSM states SHALL be IDLE, CALC and FIX; busy = (state != IDLE), decoded combinationally from the state register.
- REQ-014 IDLE with start=1 SHALL perform these actions at the edge:
  - latch magnitudes |a| and |b| (raw operands when signed_mode=0);
  - latch neg = signed_mode & (a[MSB] ^ b[MSB]);
  - clear product to 0;
  - enter CALC.
- REQ-015 Magnitude of the most negative value (e.g. 0x80000000) SHALL be its unsigned bit pattern (2^(WIDTH-1)), with no overflow.
- REQ-016 A pair (i,j) SHALL be valid when digit i of |a| and digit j of |b| are both nonzero; P = number of valid pairs, 0 <= P <= ND*ND.
- REQ-017 Each CALC cycle SHALL consume the lowest unconsumed valid pair in order j-major, i-minor, adding (a_i*b_j) << ((i+j)*DIGIT) to product.
- REQ-018 Pairs with a zero digit SHALL cost no cycles.
- REQ-019 CALC SHALL move to FIX on the cycle consuming the last valid pair, or after one cycle when P=0 (no add); CALC lasts max(P,1) cycles.
- REQ-020 FIX SHALL write product <= neg ? -product : product (mod 2^(2*WIDTH)), enter IDLE, and set done=1 for exactly the following cycle.
- REQ-021 Total latency: start edge to done cycle = max(P,1)+2 edges; busy high for max(P,1)+1 cycles.
- REQ-022 start while busy SHALL be ignored; latched operands and mode SHALL be unaffected by a, b and signed_mode changes during busy.
- REQ-023 start in the done cycle SHALL be accepted (back-to-back operation); product clears at that edge.
- REQ-024 product SHALL hold its final value in IDLE until the next accepted start; during busy it is a partial sum, valid only when done=1.
- REQ-025 The digit multiplier SHALL be a single DIGITxDIGIT unsigned unit, shared across all cycles.

Reset
- REQ-026 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, product=0, and clear all latched operands, neg and pair-consumption flags.
- REQ-027 Reset asserted mid-CALC or mid-FIX SHALL abort the operation with no done pulse; the first start after deassertion SHALL operate normally.

Verification (WIDTH=32, DIGIT=8)
- REQ-028 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFFFFFE00000001; busy 17 cycles; done one cycle.
- REQ-029 Unsigned 0x01000001 x 0x00010000 -> P=2, busy 3 cycles, product 0x0000010000010000; unsigned 0 x 0x12345678 -> busy 2 cycles, product 0.
- REQ-030 Signed 0x80000000 x 0xFFFFFFFF -> product 0x0000000080000000, busy 2 cycles; signed 0xFFFFFFF9 x 0x00000003 -> product 0xFFFFFFFFFFFFFFEB.
- REQ-031 Unsigned 0xFFFFFFF9 x 0x00000003 -> product 0x00000002FFFFFFEB (signed_mode=0 does no sign handling).
- REQ-032 Start 5 x 7; hold start=1 and toggle a/b every cycle while busy -> product 35, one done pulse; the start in the done cycle launches the next operation.
- REQ-033 Reset pulse during cycle 5 of CALC (0xFFFFFFFF x 0xFFFFFFFF) -> busy, done, product 0 immediately, no done pulse; then 2 x 3 -> product 6.
